// File: rtl/jam_gen.sv
// Exhaustive job-assignment search: walks all N! worker->job permutations in
// lexicographic order, summing costs from an external ROM, and keeps the best.
module jam_gen #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 Start,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    input  logic [COST_W-1:0]    Cost,
    output logic [SUM_W-1:0]     MinCost,
    output logic [CNT_W-1:0]     MatchCount,
    output logic [N*IDX_W-1:0]   BestPerm,
    output logic                 Busy,
    output logic                 Valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] K_LAST = PW'(N - 1);

    typedef enum logic [1:0] {IDLE, SUM, UPDATE, DONE} state_t;

    state_t                  state, state_nxt;
    logic [N-1:0][IDX_W-1:0] perm, perm_sw, perm_nxt;
    logic [PW-1:0]           k;
    logic [SUM_W-1:0]        acc;
    logic                    first;
    logic                    has_pivot;
    logic [PW-1:0]           pivot, swp;

    // Next lexicographic permutation: last ascent, swap with its rightmost
    // larger successor, then reverse the tail.
    always_comb begin
        has_pivot = 1'b0;
        pivot     = '0;
        swp       = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm[i] < perm[i+1]) begin
                has_pivot = 1'b1;
                pivot     = PW'(i);
            end
        end
        for (int m = 0; m < N; m++) begin
            if (perm[m] > perm[pivot]) swp = PW'(m);
        end
        perm_sw        = perm;
        perm_sw[pivot] = perm[swp];
        perm_sw[swp]   = perm[pivot];
        perm_nxt       = perm_sw;
        for (int m = 0; m < N; m++) begin
            if (m > int'(pivot)) perm_nxt[m] = perm_sw[PW'(N + int'(pivot) - m)];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Valid     = 1'b0;
        W         = '0;
        J         = '0;
        case (state)
            IDLE: if (Start) state_nxt = SUM;
            SUM: begin
                Busy = 1'b1;
                W    = IDX_W'(k);
                J    = perm[k];
                if (k == K_LAST) state_nxt = UPDATE;
            end
            UPDATE: begin
                Busy      = 1'b1;
                state_nxt = has_pivot ? SUM : DONE;
            end
            DONE: begin
                Valid = 1'b1;
                if (Start) state_nxt = SUM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perm       <= '0;
            k          <= '0;
            acc        <= '0;
            first      <= 1'b0;
            MinCost    <= '0;
            MatchCount <= '0;
            BestPerm   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        for (int i = 0; i < N; i++) perm[i] <= IDX_W'(i);
                        k     <= '0;
                        acc   <= '0;
                        first <= 1'b1;
                    end
                end
                SUM: begin
                    acc <= acc + SUM_W'(Cost);
                    k   <= (k == K_LAST) ? '0 : k + 1'b1;
                end
                UPDATE: begin
                    if (first || acc < MinCost) begin
                        MinCost    <= acc;
                        MatchCount <= CNT_W'(1);
                        BestPerm   <= perm;
                        first      <= 1'b0;
                    end else if (acc == MinCost && MatchCount != '1) begin
                        MatchCount <= MatchCount + 1'b1;
                    end
                    if (has_pivot) begin
                        perm <= perm_nxt;
                        acc  <= '0;
                        k    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_gen.sv
// Random and directed cost tables on a 4x4 jam_gen, compared against a
// brute-force enumeration of every job tuple.
module tb_jam_gen;
    localparam int P_N   = 4;
    localparam int P_IDX = 3;
    localparam int LAT   = 24 * (P_N + 1);

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             Start;
    logic [P_IDX-1:0] W, J;
    logic [6:0]       Cost;
    logic [9:0]       MinCost;
    logic [3:0]       MatchCount;
    logic [P_N*P_IDX-1:0] BestPerm;
    logic             Busy, Valid;

    logic [6:0] rom [P_N][P_N];
    int vecs = 0, errs = 0, wj_bad = 0;

    always #5 CLK = ~CLK;

    assign Cost = (W < 3'(P_N) && J < 3'(P_N)) ? rom[W[1:0]][J[1:0]] : 7'd0;

    jam_gen #(.N(P_N), .IDX_W(P_IDX), .COST_W(7), .SUM_W(10), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .W(W), .J(J), .Cost(Cost),
        .MinCost(MinCost), .MatchCount(MatchCount), .BestPerm(BestPerm),
        .Busy(Busy), .Valid(Valid)
    );

    always @(negedge CLK) begin
        if (RST_N) begin
            if (int'(W) >= P_N || int'(J) >= P_N) wj_bad++;
            if (!Busy && (W != 0 || J != 0)) wj_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Lexicographic order of (a,b,c,d) tuples is the permutation order.
    task automatic model(output logic [9:0] mn, output int cnt, output logic [11:0] best);
        int s;
        bit found = 0;
        mn = 0; cnt = 0; best = 0;
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++)
            for (int c = 0; c < 4; c++)
              for (int d = 0; d < 4; d++) begin
                  if (a == b || a == c || a == d || b == c || b == d || c == d) continue;
                  s = rom[0][a] + rom[1][b] + rom[2][c] + rom[3][d];
                  if (!found || s < int'(mn)) begin
                      found = 1; mn = 10'(s); cnt = 1;
                      best = {3'(d), 3'(c), 3'(b), 3'(a)};
                  end else if (s == int'(mn) && cnt < 15) cnt++;
              end
    endtask

    task automatic load(input int kind);
        for (int i = 0; i < P_N; i++)
            for (int j = 0; j < P_N; j++)
                case (kind)
                    0: rom[i][j] = (i == j) ? 7'd1 : 7'd10;
                    1: rom[i][j] = (j == P_N - 1 - i) ? 7'd0 : 7'd50;
                    2: rom[i][j] = 7'd5;
                    3: rom[i][j] = 7'($urandom_range(0, 127));
                    default: rom[i][j] = 7'($urandom_range(0, 2));
                endcase
    endtask

    task automatic kick();
        @(negedge CLK) Start = 1'b1;
        @(posedge CLK);
        #1 Start = 1'b0;
        chk("valid_drop", 32'(Valid), 0);
        chk("busy_rise", 32'(Busy), 1);
    endtask

    task automatic run(input bit inject);
        int cyc = 0;
        logic [9:0] mn; int cnt; logic [11:0] best;
        model(mn, cnt, best);
        kick();
        while (!Valid && cyc < 400) begin
            Start = (inject && cyc == 30);
            @(posedge CLK);
            #1 cyc++;
        end
        Start = 1'b0;
        chk("latency", 32'(cyc), 32'(LAT));
        chk("min_cost", 32'(MinCost), 32'(mn));
        chk("match_cnt", 32'(MatchCount), 32'(cnt));
        chk("best_perm", 32'(BestPerm), 32'(best));
        chk("busy_done", 32'(Busy), 0);
        chk("wj_idle", 32'({W, J}), 0);
    endtask

    initial begin
        RST_N = 1'b0;
        Start = 1'b0;
        load(0);
        #2;
        chk("rst_min", 32'(MinCost), 0);
        chk("rst_cnt", 32'(MatchCount), 0);
        chk("rst_best", 32'(BestPerm), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_valid", 32'(Valid), 0);
        chk("rst_wj", 32'({W, J}), 0);
        @(negedge CLK) RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        load(0); run(0);
        load(1); run(0);
        load(2); run(0);
        for (int t = 0; t < 6; t++) begin
            load((t % 2 == 0) ? 3 : 4);
            run(t[0]);
        end

        // Asynchronous reset in the middle of a search.
        load(3);
        kick();
        repeat (50) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_min", 32'(MinCost), 0);
        chk("mid_rst_cnt", 32'(MatchCount), 0);
        chk("mid_rst_best", 32'(BestPerm), 0);
        chk("mid_rst_busy", 32'(Busy), 0);
        chk("mid_rst_valid", 32'(Valid), 0);
        chk("mid_rst_wj", 32'({W, J}), 0);
        @(negedge CLK) RST_N = 1'b1;
        load(0); run(0);

        chk("wj_range", 32'(wj_bad), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
